// File: rtl/umi_isolate_gate.sv
// umi_isolate_gate
// Zero-latency isolation gate for one UMI request/response hop. Traffic passes
// straight through until isolation is requested. The clamp is applied only at a
// transaction-safe boundary, so an offered beat is never withdrawn before its
// handshake. Once clamped, valid, ready and payload are all driven to 0.
// With ISO = 0 the block reduces to wires and isolated is tied low.

module umi_isolate_gate #(
  parameter int CW  = 32,
  parameter int AW  = 64,
  parameter int DW  = 256,
  parameter int ISO = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          isolate,
  output logic          isolated,
  input  logic          umi_valid,
  input  logic [CW-1:0] umi_cmd,
  input  logic [AW-1:0] umi_dstaddr,
  input  logic [AW-1:0] umi_srcaddr,
  input  logic [DW-1:0] umi_data,
  output logic          umi_ready_iso,
  output logic          umi_valid_iso,
  output logic [CW-1:0] umi_cmd_iso,
  output logic [AW-1:0] umi_dstaddr_iso,
  output logic [AW-1:0] umi_srcaddr_iso,
  output logic [DW-1:0] umi_data_iso,
  input  logic          umi_ready
);

  // PASS and DRAIN both pass traffic; DRAIN only remembers that a request is
  // waiting for the in-flight beat to be accepted.
  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISO   = 2'd2
  } state_t;

  generate
    if (ISO != 0) begin : g_iso
      state_t state_reg;
      logic   clamp;
      logic   safe_boundary;

      // A beat may be cut off only when nothing is offered or it is being accepted now.
      assign safe_boundary = !umi_valid || umi_ready;

      // Isolation state: reset lands in ISO so nothing leaks while the sink is unknown.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= S_ISO;
        end else begin
          case (state_reg)
            S_PASS: begin
              if (isolate) state_reg <= safe_boundary ? S_ISO : S_DRAIN;
            end
            S_DRAIN: begin
              if (!isolate)          state_reg <= S_PASS;
              else if (safe_boundary) state_reg <= S_ISO;
            end
            S_ISO: begin
              if (!isolate) state_reg <= S_PASS;
            end
            default: state_reg <= S_ISO;
          endcase
        end
      end

      // Any state other than the two pass-through states clamps, so an
      // unexpected encoding can never expose the downstream side.
      assign clamp = !((state_reg == S_PASS) || (state_reg == S_DRAIN));

      assign isolated        = clamp;
      assign umi_valid_iso   = umi_valid & ~clamp;
      assign umi_ready_iso   = umi_ready & ~clamp;
      assign umi_cmd_iso     = clamp ? '0 : umi_cmd;
      assign umi_dstaddr_iso = clamp ? '0 : umi_dstaddr;
      assign umi_srcaddr_iso = clamp ? '0 : umi_srcaddr;
      assign umi_data_iso    = clamp ? '0 : umi_data;
    end else begin : g_wire
      // No isolation hardware: clock, reset and request are intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, isolate};

      assign isolated        = 1'b0;
      assign umi_valid_iso   = umi_valid;
      assign umi_ready_iso   = umi_ready;
      assign umi_cmd_iso     = umi_cmd;
      assign umi_dstaddr_iso = umi_dstaddr;
      assign umi_srcaddr_iso = umi_srcaddr;
      assign umi_data_iso    = umi_data;
    end
  endgenerate

endmodule

// File: tb/tb_umi_isolate_gate.sv
// tb_umi_isolate_gate
// Randomized bench for umi_isolate_gate. A one-bit "clamped" reference model
// predicts every output each cycle; a packet scoreboard checks in-order,
// lossless, duplicate-free delivery. A second instance built with ISO = 0
// shares the same stimulus and must always behave as plain wires.

module tb_umi_isolate_gate;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int PW = CW + 2 * AW + DW;
  localparam int N  = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          isolate = 1'b0;
  logic          umi_valid = 1'b0;
  logic [CW-1:0] umi_cmd = '0;
  logic [AW-1:0] umi_dstaddr = '0;
  logic [AW-1:0] umi_srcaddr = '0;
  logic [DW-1:0] umi_data = '0;
  logic          umi_ready = 1'b0;

  logic          isolated, umi_ready_iso, umi_valid_iso;
  logic [CW-1:0] umi_cmd_iso;
  logic [AW-1:0] umi_dstaddr_iso, umi_srcaddr_iso;
  logic [DW-1:0] umi_data_iso;

  logic          w_isolated, w_ready_iso, w_valid_iso;
  logic [CW-1:0] w_cmd_iso;
  logic [AW-1:0] w_dstaddr_iso, w_srcaddr_iso;
  logic [DW-1:0] w_data_iso;

  umi_isolate_gate #(.CW(CW), .AW(AW), .DW(DW), .ISO(1)) dut (
    .clk(clk), .reset(reset), .isolate(isolate), .isolated(isolated),
    .umi_valid(umi_valid), .umi_cmd(umi_cmd), .umi_dstaddr(umi_dstaddr),
    .umi_srcaddr(umi_srcaddr), .umi_data(umi_data),
    .umi_ready_iso(umi_ready_iso), .umi_valid_iso(umi_valid_iso),
    .umi_cmd_iso(umi_cmd_iso), .umi_dstaddr_iso(umi_dstaddr_iso),
    .umi_srcaddr_iso(umi_srcaddr_iso), .umi_data_iso(umi_data_iso),
    .umi_ready(umi_ready)
  );

  umi_isolate_gate #(.CW(CW), .AW(AW), .DW(DW), .ISO(0)) dut_wire (
    .clk(clk), .reset(reset), .isolate(isolate), .isolated(w_isolated),
    .umi_valid(umi_valid), .umi_cmd(umi_cmd), .umi_dstaddr(umi_dstaddr),
    .umi_srcaddr(umi_srcaddr), .umi_data(umi_data),
    .umi_ready_iso(w_ready_iso), .umi_valid_iso(w_valid_iso),
    .umi_cmd_iso(w_cmd_iso), .umi_dstaddr_iso(w_dstaddr_iso),
    .umi_srcaddr_iso(w_srcaddr_iso), .umi_data_iso(w_data_iso),
    .umi_ready(umi_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [PW-1:0] in_p, out_p, wout_p;
  assign in_p   = {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data};
  assign out_p  = {umi_cmd_iso, umi_dstaddr_iso, umi_srcaddr_iso, umi_data_iso};
  assign wout_p = {w_cmd_iso, w_dstaddr_iso, w_srcaddr_iso, w_data_iso};

  // Reference: the gate is either clamped or transparent. It clamps at an edge
  // where isolation is requested and no beat is stalled; it opens at any edge
  // where isolation is not requested.
  logic m_clamped = 1'b1;
  always @(posedge clk or posedge reset) begin
    if (reset)           m_clamped <= 1'b1;
    else if (!isolate)   m_clamped <= 1'b0;
    else if (!umi_valid || umi_ready) m_clamped <= 1'b1;
  end

  // Packet store and scoreboard.
  logic [PW-1:0] pkt [N];
  int  src_idx = 0;
  int  rx_idx  = 0;
  bit  sb_en   = 1'b0;
  bit  hs_up   = 1'b0;

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    chk("isolated",  {{(PW-1){1'b0}}, isolated},      {{(PW-1){1'b0}}, m_clamped});
    chk("valid_iso", {{(PW-1){1'b0}}, umi_valid_iso}, {{(PW-1){1'b0}}, umi_valid & ~m_clamped});
    chk("ready_iso", {{(PW-1){1'b0}}, umi_ready_iso}, {{(PW-1){1'b0}}, umi_ready & ~m_clamped});
    chk("payload_iso", out_p, m_clamped ? '0 : in_p);
    chk("wire_isolated", {{(PW-1){1'b0}}, w_isolated}, '0);
    chk("wire_valid", {{(PW-1){1'b0}}, w_valid_iso}, {{(PW-1){1'b0}}, umi_valid});
    chk("wire_ready", {{(PW-1){1'b0}}, w_ready_iso}, {{(PW-1){1'b0}}, umi_ready});
    chk("wire_payload", wout_p, in_p);
    hs_up = umi_valid && umi_ready_iso;
    if (sb_en && umi_valid_iso && umi_ready) begin
      if (rx_idx >= N) begin
        chk("rx_extra_beat", {{(PW-32){1'b0}}, rx_idx}, {{(PW-32){1'b0}}, N - 1});
      end else begin
        chk($sformatf("rx_pkt%0d", rx_idx), out_p, pkt[rx_idx]);
      end
      rx_idx++;
    end
  end

  task automatic pin(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    chk(nm, act, exp);
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #3;
  endtask

  task automatic rand_payload(output logic [PW-1:0] p);
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
  endtask

  logic [PW-1:0] pat_a, pat_b, junk;
  int vprob, rprob;
  bit done;

  initial begin
    for (int i = 0; i < N; i++) begin
      rand_payload(junk);
      pkt[i] = junk;
    end

    // Reset: clamped regardless of what upstream offers.
    repeat (3) @(posedge clk);
    #3;
    pin("rst_isolated", {{(PW-1){1'b0}}, isolated}, 1);
    umi_valid = 1'b1;
    umi_ready = 1'b1;
    {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = pkt[0];
    #1;
    pin("rst_valid_iso", {{(PW-1){1'b0}}, umi_valid_iso}, 0);
    pin("rst_ready_iso", {{(PW-1){1'b0}}, umi_ready_iso}, 0);
    pin("rst_payload", out_p, 0);
    umi_valid = 1'b0;
    umi_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    edge_settle();
    pin("release_isolated", {{(PW-1){1'b0}}, isolated}, 0);

    // A pulse of isolate between edges is never sampled.
    isolate = 1'b1;
    #1 isolate = 1'b0;
    edge_settle();
    pin("glitch_isolated", {{(PW-1){1'b0}}, isolated}, 0);

    // Idle isolate: clamps one edge later, then blocks a new offer.
    umi_valid = 1'b0;
    isolate = 1'b1;
    edge_settle();
    pin("idle_isolated", {{(PW-1){1'b0}}, isolated}, 1);
    pat_a = {(PW/8){8'hA5}};
    {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = pat_a;
    umi_valid = 1'b1;
    umi_ready = 1'b1;
    #1;
    pin("idle_valid_iso", {{(PW-1){1'b0}}, umi_valid_iso}, 0);
    pin("idle_ready_iso", {{(PW-1){1'b0}}, umi_ready_iso}, 0);
    pin("idle_data_iso", {{(PW-DW){1'b0}}, umi_data_iso}, 0);
    umi_valid = 1'b0;
    umi_ready = 1'b0;
    isolate = 1'b0;
    edge_settle();
    pin("idle_release", {{(PW-1){1'b0}}, isolated}, 0);

    // Mid-transaction: the stalled beat stays visible until accepted.
    rand_payload(pat_a);
    {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = pat_a;
    umi_valid = 1'b1;
    umi_ready = 1'b0;
    isolate = 1'b1;
    edge_settle();
    pin("drain_isolated", {{(PW-1){1'b0}}, isolated}, 0);
    pin("drain_valid_iso", {{(PW-1){1'b0}}, umi_valid_iso}, 1);
    pin("drain_payload", out_p, pat_a);
    edge_settle();
    pin("drain_hold_payload", out_p, pat_a);
    umi_ready = 1'b1;
    #1;
    pin("drain_hs_ready_iso", {{(PW-1){1'b0}}, umi_ready_iso}, 1);
    edge_settle();
    rand_payload(pat_b);
    {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = pat_b;
    #1;
    pin("drain_to_iso", {{(PW-1){1'b0}}, isolated}, 1);
    pin("next_beat_blocked", {{(PW-1){1'b0}}, umi_valid_iso}, 0);

    // Release: still clamped until the edge that samples isolate low.
    isolate = 1'b0;
    #1;
    pin("release_pre_edge", {{(PW-1){1'b0}}, umi_valid_iso}, 0);
    edge_settle();
    pin("release_valid_iso", {{(PW-1){1'b0}}, umi_valid_iso}, 1);
    pin("release_payload", out_p, pat_b);
    umi_valid = 1'b0;
    umi_ready = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic with in-order scoreboard; isolate toggles in the second half.
    sb_en = 1'b1;
    vprob = 50;
    rprob = 50;
    done = 1'b0;
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (umi_valid && hs_up) src_idx++;
      if (!umi_valid || hs_up) begin
        if (src_idx < N && $urandom_range(99) < vprob) begin
          umi_valid = 1'b1;
          {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = pkt[src_idx];
        end else begin
          umi_valid = 1'b0;
          rand_payload(junk);
          {umi_cmd, umi_dstaddr, umi_srcaddr, umi_data} = junk;
        end
      end
      umi_ready = ($urandom_range(99) < rprob);
      if (cyc % 100 == 0) begin
        vprob = 10 + 30 * $urandom_range(3);
        rprob = 10 + 30 * $urandom_range(3);
      end
      if (src_idx >= N / 2) begin
        if ($urandom_range(19) == 0) isolate = ~isolate;
      end else begin
        isolate = 1'b0;
      end
      if (src_idx == N) done = 1'b1;
    end
    umi_valid = 1'b0;
    umi_ready = 1'b0;
    isolate = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    pin("src_all_sent", {{(PW-32){1'b0}}, src_idx}, {{(PW-32){1'b0}}, N});
    pin("rx_all_received", {{(PW-32){1'b0}}, rx_idx}, {{(PW-32){1'b0}}, N});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
